glove_frame_assembler: RTL and testbench

//  Upstream stage of the recognition core. Collects the glove sensor sample stream (one 16-bit sample
//  per accepted beat, start-of-frame marked) into a 40-sample frame, double-buffers it, and presents
//  a stable frame to the core with a one-cycle o_next pulse, only when the core reports idle.

---
 rtl/glove_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/glove_frame_assembler.sv | 137 +++++++++++++
 tb/tb_glove_frame_assembler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glove_pkg.sv
// Shared constants and types for the glove frame assembler.
package glove_pkg;

   localparam int unsigned N_SAMPLES = 40;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned FCNT_W    = 16;

   typedef logic [DATA_W-1:0] sample_t;
   typedef sample_t frame_t [0:N_SAMPLES-1];

   typedef enum logic [0:0] {
      WAIT_SOF = 1'b0,
      FILL     = 1'b1
   } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, hold at all-ones, clear wins.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/glove_frame_assembler.sv
// Collects start-of-frame-marked samples into a frame, double-buffers it and
// hands the newest complete frame to the core with a one-cycle o_next pulse.
module glove_frame_assembler
   import glove_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic                 i_sof,
   input  logic [DATA_W-1:0]    i_sample,
   output logic                 o_ready,
   input  logic                 i_core_ready,
   output logic                 o_next,
   output logic [DATA_W-1:0]    o_data [0:N_SAMPLES-1],
   output logic [FCNT_W-1:0]    o_frame_count,
   output logic [CNT_W-1:0]     o_drop_count,
   output logic [CNT_W-1:0]     o_resync_count
);

   fill_state_e        state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [IDX_W-1:0]   wr_idx;
   logic               wr_en;
   logic               complete;
   logic               resync_inc;
   logic               pending;
   logic               issue;
   logic               drop_inc;
   frame_t             shadow;

   // Fill state and sample index register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= WAIT_SOF;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state, shadow write and frame-completion decode.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      wr_en      = 1'b0;
      wr_idx     = idx;
      complete   = 1'b0;
      resync_inc = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (i_valid && i_sof) begin
               wr_en     = 1'b1;
               wr_idx    = '0;
               idx_nxt   = IDX_W'(1);
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (i_valid && i_sof) begin
               resync_inc = 1'b1;
               wr_en      = 1'b1;
               wr_idx     = '0;
               idx_nxt    = IDX_W'(1);
            end else if (i_valid) begin
               if (idx == IDX_W'(N_SAMPLES - 1)) begin
                  complete  = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = WAIT_SOF;
               end else begin
                  wr_en   = 1'b1;
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end

   assign issue    = pending && !o_next && i_core_ready;
   assign drop_inc = complete && pending && !o_next;

   // Shadow buffer collects the frame being filled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < N_SAMPLES; i++) shadow[i] <= '0;
      end else if (wr_en) begin
         shadow[wr_idx] <= i_sample;
      end
   end

   // Output buffer loads on completion; the last sample bypasses the shadow.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < N_SAMPLES; i++) o_data[i] <= '0;
      end else if (complete) begin
         for (int unsigned i = 0; i < N_SAMPLES - 1; i++) o_data[i] <= shadow[i];
         o_data[N_SAMPLES-1] <= i_sample;
      end
   end

   // Pending flag, issue pulse and issued-frame counter; a new completion wins over an issue.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pending       <= 1'b0;
         o_next        <= 1'b0;
         o_frame_count <= '0;
         o_ready       <= 1'b0;
      end else begin
         o_ready <= 1'b1;
         o_next  <= issue;
         if (complete) begin
            pending <= 1'b1;
         end else if (issue) begin
            pending <= 1'b0;
         end
         if (issue) begin
            o_frame_count <= o_frame_count + FCNT_W'(1);
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (i_clk),
      .clr   (!i_rst_n),
      .inc   (drop_inc),
      .count (o_drop_count)
   );

   sat_counter #(.W(CNT_W)) u_resync_cnt (
      .clk   (i_clk),
      .clr   (!i_rst_n),
      .inc   (resync_inc),
      .count (o_resync_count)
   );

endmodule

// File: tb/tb_glove_frame_assembler.sv
// Directed bench for glove_frame_assembler with a queue-based frame model.
module tb_glove_frame_assembler;

   localparam int NS = 40;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_sof = 1'b0;
   logic [15:0] i_sample = '0;
   logic        i_core_ready = 1'b0;
   logic        o_ready;
   logic        o_next;
   logic [15:0] o_data [0:NS-1];
   logic [15:0] o_frame_count;
   logic [7:0]  o_drop_count;
   logic [7:0]  o_resync_count;

   int tests = 0;
   int fails = 0;

   glove_frame_assembler dut (
      .i_clk          (clk),
      .i_rst_n        (i_rst_n),
      .i_valid        (i_valid),
      .i_sof          (i_sof),
      .i_sample       (i_sample),
      .o_ready        (o_ready),
      .i_core_ready   (i_core_ready),
      .o_next         (o_next),
      .o_data         (o_data),
      .o_frame_count  (o_frame_count),
      .o_drop_count   (o_drop_count),
      .o_resync_count (o_resync_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: current partial frame as a queue, latest complete frame, handshake flags.
   logic [15:0] cur [$];
   logic [15:0] m_data [0:NS-1];
   bit          m_init = 0;
   bit          m_pend, m_next, m_ready;
   int          m_fcnt, m_drop, m_resync;

   always @(posedge clk) begin
      bit done, iss;
      if (!i_rst_n) begin
         cur.delete();
         for (int i = 0; i < NS; i++) m_data[i] = '0;
         m_pend = 0; m_next = 0; m_ready = 0;
         m_fcnt = 0; m_drop = 0; m_resync = 0;
         m_init = 1;
      end else begin
         done = 0;
         m_ready = 1;
         if (i_valid) begin
            if (i_sof) begin
               if (cur.size() > 0 && m_resync < 255) m_resync++;
               cur.delete();
               cur.push_back(i_sample);
            end else if (cur.size() > 0) begin
               cur.push_back(i_sample);
               if (cur.size() == NS) done = 1;
            end
         end
         iss = m_pend && !m_next && i_core_ready;
         if (done && m_pend && !m_next && m_drop < 255) m_drop++;
         if (iss) m_fcnt = (m_fcnt + 1) % 65536;
         if (done) begin
            for (int i = 0; i < NS; i++) m_data[i] = cur[i];
            cur.delete();
            m_pend = 1;
         end else if (iss) begin
            m_pend = 0;
         end
         m_next = iss;
      end
   end

   // Every cycle after the first reset, DUT outputs must equal the model.
   always @(negedge clk) begin
      int bad;
      if (m_init) begin
         chk("cyc_ready", 32'(o_ready), 32'(m_ready));
         chk("cyc_next", 32'(o_next), 32'(m_next));
         chk("cyc_frame_count", 32'(o_frame_count), 32'(m_fcnt));
         chk("cyc_drop", 32'(o_drop_count), 32'(m_drop));
         chk("cyc_resync", 32'(o_resync_count), 32'(m_resync));
         bad = -1;
         for (int i = 0; i < NS; i++) if (o_data[i] !== m_data[i]) bad = i;
         chk("cyc_data_bad_index", 32'(bad), 32'hFFFF_FFFF);
      end
   end

   // Core model: latch the frame while o_next is high.
   logic [15:0] core_latch [0:NS-1];
   always @(negedge clk) begin
      if (o_next === 1'b1) for (int i = 0; i < NS; i++) core_latch[i] = o_data[i];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit sof, input logic [15:0] s);
      i_valid = 1'b1; i_sof = sof; i_sample = s;
      tick();
      i_valid = 1'b0; i_sof = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base);
      beat(1'b1, base);
      for (int k = 1; k < NS; k++) beat(1'b0, base + 16'(k));
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
      tick();
      chk("rst_ready", 32'(o_ready), 0);
      chk("rst_next", 32'(o_next), 0);
      chk("rst_fcnt", 32'(o_frame_count), 0);
      chk("rst_drop", 32'(o_drop_count), 0);
      chk("rst_resync", 32'(o_resync_count), 0);
      chk("rst_data0", 32'(o_data[0]), 0);
      chk("rst_data39", 32'(o_data[NS-1]), 0);
      i_rst_n = 1'b1;
   endtask

   task automatic wait_next(input int max);
      bit got = 0;
      for (int n = 0; n < max && !got; n++) begin
         tick();
         if (o_next === 1'b1) got = 1;
      end
      chk("wait_next_timeout", 32'(got), 1);
   endtask

   initial begin
      int p;
      // 1: single frame, core ready
      do_reset();
      i_core_ready = 1'b1;
      tick();
      chk("t1_ready_after_reset", 32'(o_ready), 1);
      send_frame(16'd1);
      chk("t1_next_not_yet", 32'(o_next), 0);
      chk("t1_data0", 32'(o_data[0]), 1);
      chk("t1_data39", 32'(o_data[NS-1]), 40);
      tick();
      chk("t1_next_pulse", 32'(o_next), 1);
      chk("t1_fcnt", 32'(o_frame_count), 1);
      tick();
      chk("t1_next_one_cycle", 32'(o_next), 0);
      chk("t1_core_latch0", 32'(core_latch[0]), 1);

      // 2: two frames while core busy -> one drop, newest kept
      do_reset();
      i_core_ready = 1'b0;
      send_frame(16'd200);
      send_frame(16'd300);
      repeat (3) tick();
      chk("t2_no_next", 32'(o_next), 0);
      chk("t2_drop", 32'(o_drop_count), 1);
      chk("t2_data0", 32'(o_data[0]), 300);
      chk("t2_data39", 32'(o_data[NS-1]), 339);
      i_core_ready = 1'b1;
      p = 0;
      repeat (6) begin tick(); if (o_next === 1'b1) p++; end
      chk("t2_pulses", 32'(p), 1);
      chk("t2_fcnt", 32'(o_frame_count), 1);

      // 3: early sof resyncs
      do_reset();
      beat(1'b1, 16'd500);
      for (int k = 1; k <= 10; k++) beat(1'b0, 16'(500 + k));
      send_frame(16'd600);
      wait_next(10);
      chk("t3_resync", 32'(o_resync_count), 1);
      chk("t3_data0", 32'(o_data[0]), 600);
      chk("t3_data39", 32'(o_data[NS-1]), 639);

      // 4: beats before first sof are ignored
      do_reset();
      for (int k = 0; k < 5; k++) beat(1'b0, 16'(900 + k));
      send_frame(16'd700);
      wait_next(10);
      chk("t4_data0", 32'(o_data[0]), 700);
      chk("t4_data39", 32'(o_data[NS-1]), 739);
      chk("t4_resync", 32'(o_resync_count), 0);

      // 5: completion on the o_next cycle is not a drop
      do_reset();
      i_core_ready = 1'b0;
      send_frame(16'd2000);
      tick();
      beat(1'b1, 16'd3000);
      for (int k = 1; k <= 37; k++) beat(1'b0, 16'(3000 + k));
      i_core_ready = 1'b1;
      beat(1'b0, 16'd3038);
      i_core_ready = 1'b0;
      beat(1'b0, 16'd3039);
      chk("t5_drop", 32'(o_drop_count), 0);
      chk("t5_latch_old0", 32'(core_latch[0]), 2000);
      chk("t5_latch_old39", 32'(core_latch[NS-1]), 2039);
      chk("t5_data_new0", 32'(o_data[0]), 3000);
      chk("t5_fcnt1", 32'(o_frame_count), 1);
      i_core_ready = 1'b1;
      wait_next(10);
      tick();
      chk("t5_latch_new0", 32'(core_latch[0]), 3000);
      chk("t5_latch_new39", 32'(core_latch[NS-1]), 3039);
      chk("t5_fcnt2", 32'(o_frame_count), 2);

      // 6: reset mid-frame clears pending and partial frame
      do_reset();
      i_core_ready = 1'b0;
      send_frame(16'd800);
      beat(1'b1, 16'd1000);
      for (int k = 1; k < 20; k++) beat(1'b0, 16'(1000 + k));
      chk("t6_data_before", 32'(o_data[0]), 800);
      do_reset();
      i_core_ready = 1'b1;
      p = 0;
      repeat (4) begin tick(); if (o_next === 1'b1) p++; end
      chk("t6_no_stale_issue", 32'(p), 0);
      send_frame(16'd1100);
      wait_next(10);
      chk("t6_data0", 32'(o_data[0]), 1100);
      chk("t6_fcnt", 32'(o_frame_count), 1);

      // 7: resync counter saturates
      do_reset();
      repeat (260) beat(1'b1, 16'd7);
      tick();
      chk("t7_resync_sat", 32'(o_resync_count), 255);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
